// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a one-word hold buffer
// for IR back-pressure, and branch redirect handling with a sticky misalignment flag.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fetch_en,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             ir_ready,
  output logic             ir_load,
  output logic [WIDTH-1:0] ir_data,
  output logic [WIDTH-1:0] pc_out,
  output logic             fetch_err
);

  // REQ is the only encoding with bit 2 set, so mem_req comes straight off a flop.
  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_WAIT = 3'b001,
    S_HOLD = 3'b010,
    S_DROP = 3'b011,
    S_REQ  = 3'b100
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(3'd4);

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_hold_data;
  logic [WIDTH-1:0] r_hold_pc;
  logic [WIDTH-1:0] r_ir_data;
  logic [WIDTH-1:0] r_pc_out;
  logic             r_ir_load;
  logic             r_err;

  logic w_aligned;
  logic w_go;
  logic w_err_nxt;

  assign w_aligned = (redirect_pc[1:0] == 2'b00);
  assign w_go      = w_aligned & fetch_en;
  assign w_err_nxt = redirect ? ~w_aligned : r_err;

  assign mem_req   = r_state[2];
  assign mem_addr  = r_pc;
  assign ir_load   = r_ir_load;
  assign ir_data   = r_ir_data;
  assign pc_out    = r_pc_out;
  assign fetch_err = r_err;

  // Fetch FSM, pc, hold buffer and IR/PC output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_hold_data <= {WIDTH{1'b0}};
      r_hold_pc   <= {WIDTH{1'b0}};
      r_ir_data   <= {WIDTH{1'b0}};
      r_pc_out    <= RESET_PC;
      r_ir_load   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ir_load <= 1'b0;
      if (redirect) begin
        // A misaligned target keeps pc and parks in IDLE instead of refetching.
        r_err <= ~w_aligned;
        if (w_aligned) begin
          r_pc <= redirect_pc;
        end
        case (r_state)
          S_IDLE: r_state <= w_go ? S_REQ : S_IDLE;
          S_REQ:  r_state <= mem_ready ? S_DROP : (w_go ? S_REQ : S_IDLE);
          S_WAIT: r_state <= mem_rvalid ? (w_go ? S_REQ : S_IDLE) : S_DROP;
          S_HOLD: begin
            r_state     <= w_go ? S_REQ : S_IDLE;
            r_hold_data <= {WIDTH{1'b0}};
            r_hold_pc   <= {WIDTH{1'b0}};
          end
          S_DROP: begin
            if (mem_rvalid) begin
              r_state <= (fetch_en && !w_err_nxt) ? S_REQ : S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else begin
        case (r_state)
          S_IDLE: begin
            if (fetch_en && !r_err) begin
              r_state <= S_REQ;
            end
          end
          S_REQ: begin
            if (mem_ready) begin
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (mem_rvalid) begin
              if (ir_ready) begin
                r_ir_data <= mem_rdata;
                r_pc_out  <= r_pc;
                r_ir_load <= 1'b1;
                r_pc      <= r_pc + PC_STEP;
                r_state   <= fetch_en ? S_REQ : S_IDLE;
              end else begin
                r_hold_data <= mem_rdata;
                r_hold_pc   <= r_pc;
                r_state     <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (ir_ready) begin
              r_ir_data <= r_hold_data;
              r_pc_out  <= r_hold_pc;
              r_ir_load <= 1'b1;
              r_pc      <= r_hold_pc + PC_STEP;
              r_state   <= fetch_en ? S_REQ : S_IDLE;
            end
          end
          S_DROP: begin
            if (mem_rvalid) begin
              r_state <= (fetch_en && !r_err) ? S_REQ : S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        ir_ready = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        ir_load;
  logic [31:0] ir_data;
  logic [31:0] pc_out;
  logic        fetch_err;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rstn(rstn), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ir_ready(ir_ready), .ir_load(ir_load), .ir_data(ir_data),
    .pc_out(pc_out), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the fetcher is doing, described as transaction facts.
  bit          m_asking;    // request presented to memory
  bit          m_inflight;  // request accepted, response not yet seen
  bit          m_discard;   // in-flight response belongs to a stale pc
  bit          m_held;      // a fetched word waits for the IR
  logic [31:0] m_pc, m_hd, m_hpc, m_ird, m_pco;
  bit          m_load, m_err;

  // Memory responder and knobs.
  bit          rs_pend;
  int          rs_cnt;
  logic [31:0] rs_data;
  bit          rand_mode = 1'b0;
  bit          force_nrdy = 1'b0;
  int          g_lat = 0;
  bit          use_fixed = 1'b1;
  logic [31:0] fixed_data = 32'h13;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_asking = 0; m_inflight = 0; m_discard = 0; m_held = 0;
    m_pc = 32'h0; m_hd = 32'h0; m_hpc = 32'h0; m_ird = 32'h0; m_pco = 32'h0;
    m_load = 0; m_err = 0;
  endtask

  task automatic model_load(input logic [31:0] d, input logic [31:0] p);
    m_ird = d; m_pco = p; m_load = 1; m_pc = p + 32'd4; m_asking = fetch_en;
  endtask

  task automatic model_step();
    bit al, go;
    if (!rstn) begin
      model_reset();
      return;
    end
    m_load = 0;
    if (redirect) begin
      al = (redirect_pc[1:0] == 2'b00);
      if (al) begin m_pc = redirect_pc; m_err = 0; end
      else m_err = 1;
      go = al && fetch_en;
      if ((m_asking && mem_ready) || (m_inflight && !m_discard && !mem_rvalid)) begin
        m_asking = 0; m_inflight = 1; m_discard = 1;
      end else if (m_inflight && m_discard) begin
        if (mem_rvalid) begin m_inflight = 0; m_discard = 0; m_asking = fetch_en && !m_err; end
      end else begin
        m_asking = go; m_inflight = 0; m_discard = 0; m_held = 0;
      end
    end else if (m_asking) begin
      if (mem_ready) begin m_asking = 0; m_inflight = 1; end
    end else if (m_inflight && !m_discard) begin
      if (mem_rvalid) begin
        m_inflight = 0;
        if (ir_ready) model_load(mem_rdata, m_pc);
        else begin m_held = 1; m_hd = mem_rdata; m_hpc = m_pc; end
      end
    end else if (m_inflight) begin
      if (mem_rvalid) begin m_inflight = 0; m_discard = 0; m_asking = fetch_en && !m_err; end
    end else if (m_held) begin
      if (ir_ready) begin m_held = 0; model_load(m_hd, m_hpc); end
    end else begin
      m_asking = fetch_en && !m_err;
    end
  endtask

  task automatic drive_mem();
    mem_ready = force_nrdy ? 1'b0 : (rand_mode ? ($urandom % 3 != 0) : 1'b1);
    if (rs_pend && rs_cnt == 0) begin
      mem_rvalid = 1'b1; mem_rdata = rs_data;
    end else if (rand_mode && !rs_pend && ($urandom % 6 == 0)) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
    end else begin
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
  endtask

  task automatic compare_model();
    chk("mem_req",   32'(mem_req),   32'(m_asking));
    chk("mem_addr",  mem_addr,       m_pc);
    chk("ir_load",   32'(ir_load),   32'(m_load));
    chk("ir_data",   ir_data,        m_ird);
    chk("pc_out",    pc_out,         m_pco);
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
  endtask

  // One clock: drive memory, advance model, let the DUT clock, compare at negedge.
  task automatic tick();
    bit acc;
    drive_mem();
    acc = rstn && m_asking && mem_ready;
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (!rstn) rs_pend = 0;
    else begin
      if (rs_pend) begin
        if (rs_cnt == 0) rs_pend = 0;
        else rs_cnt--;
      end
      if (acc) begin
        rs_pend = 1;
        rs_cnt  = rand_mode ? int'($urandom_range(0, 3)) : g_lat;
        rs_data = use_fixed ? fixed_data : $urandom;
      end
    end
    compare_model();
  endtask

  initial begin
    logic [31:0] tmp;
    int sel;
    ir_ready = 1'b1;
    rs_pend = 0; rs_cnt = 0; rs_data = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_ir_load", 32'(ir_load), 32'h0);
    chk("rst_ir_data", ir_data, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);

    // Sequential fetch, one-cycle memory
    rstn = 1'b1; fetch_en = 1'b1;
    tick(); chk("seq_req0", 32'(mem_req), 32'h1); chk("seq_addr0", mem_addr, 32'h0);
    tick(); chk("seq_wait", 32'(mem_req), 32'h0);
    tick(); chk("seq_load0", 32'(ir_load), 32'h1); chk("seq_data0", ir_data, 32'h13);
    chk("seq_pc0", pc_out, 32'h0); chk("seq_addr4", mem_addr, 32'h4);
    tick(); tick(); chk("seq_load1", 32'(ir_load), 32'h1); chk("seq_pc1", pc_out, 32'h4);

    // IR back-pressure through the hold buffer
    fixed_data = 32'hDEADBEEF; ir_ready = 1'b0;
    tick(); tick(); chk("hold_noload", 32'(ir_load), 32'h0); chk("hold_noreq", 32'(mem_req), 32'h0);
    repeat (4) begin
      tick(); chk("hold_noload", 32'(ir_load), 32'h0); chk("hold_noreq", 32'(mem_req), 32'h0);
    end
    ir_ready = 1'b1;
    tick(); chk("hold_load", 32'(ir_load), 32'h1); chk("hold_data", ir_data, 32'hDEADBEEF);
    chk("hold_pc", pc_out, 32'h8); chk("hold_next", mem_addr, 32'hC);

    // Redirect while waiting: the stale response is dropped
    use_fixed = 1'b0; g_lat = 2;
    tick(); chk("rdw_wait", 32'(mem_req), 32'h0);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick(); redirect = 1'b0; g_lat = 0;
    chk("rdw_noload", 32'(ir_load), 32'h0); chk("rdw_addr", mem_addr, 32'h100);
    tick(); chk("rdw_noload2", 32'(ir_load), 32'h0);
    tick(); chk("rdw_noload3", 32'(ir_load), 32'h0); chk("rdw_req", 32'(mem_req), 32'h1);
    chk("rdw_addr2", mem_addr, 32'h100);
    tick(); tick(); chk("rdw_load", 32'(ir_load), 32'h1); chk("rdw_pc", pc_out, 32'h100);

    // Misaligned redirect then recovery
    force_nrdy = 1'b1; redirect = 1'b1; redirect_pc = 32'h102;
    tick(); redirect = 1'b0;
    chk("mis_err", 32'(fetch_err), 32'h1); chk("mis_noreq", 32'(mem_req), 32'h0);
    chk("mis_pc", mem_addr, 32'h104);
    tick(); chk("mis_idle", 32'(mem_req), 32'h0); chk("mis_sticky", 32'(fetch_err), 32'h1);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick(); redirect = 1'b0; force_nrdy = 1'b0;
    chk("mis_clr", 32'(fetch_err), 32'h0); chk("mis_req", 32'(mem_req), 32'h1);
    chk("mis_addr", mem_addr, 32'h200);
    tick(); tick(); chk("mis_load", 32'(ir_load), 32'h1); chk("mis_lpc", pc_out, 32'h200);

    // Asynchronous reset in the middle of a transaction
    force_nrdy = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick(); redirect = 1'b0; force_nrdy = 1'b0;
    chk("ar_addr", mem_addr, 32'h40);
    g_lat = 3;
    tick(); chk("ar_wait", 32'(mem_req), 32'h0);
    rstn = 1'b0; #1;
    chk("ar_req", 32'(mem_req), 32'h0); chk("ar_maddr", mem_addr, 32'h0);
    chk("ar_load", 32'(ir_load), 32'h0); chk("ar_data", ir_data, 32'h0);
    chk("ar_pc", pc_out, 32'h0); chk("ar_err", 32'(fetch_err), 32'h0);
    g_lat = 0;
    tick(); tick();
    rstn = 1'b1;
    tick(); chk("ar_first", 32'(mem_req), 32'h1); chk("ar_faddr", mem_addr, 32'h0);

    // Address wrap at the top of memory
    force_nrdy = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect = 1'b0; force_nrdy = 1'b0;
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    tick(); tick(); chk("wrap_load", 32'(ir_load), 32'h1);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC); chk("wrap_next", mem_addr, 32'h0);

    // Randomized traffic against the model
    rand_mode = 1'b1;
    repeat (4000) begin
      fetch_en = ($urandom % 5 != 0);
      ir_ready = ($urandom % 3 != 0);
      redirect = ($urandom % 14 == 0);
      if (redirect) fetch_en = 1'b1;
      tmp = $urandom;
      sel = int'($urandom % 4);
      redirect_pc = (sel == 0) ? tmp : ((sel == 1) ? 32'hFFFF_FFF8 : (tmp & 32'h0000_03FC));
      rstn = ($urandom % 300 != 0);
      tick();
    end
    rstn = 1'b1; redirect = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: WIDTH, 32, data/address width.
REQ-002 Parameter: RESET_PC, 0, fetch address after reset.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port: fetch_en  input  1  core permits new fetches.
REQ-006 Port: redirect  input  1  branch/jump redirect strobe.
REQ-007 Port: redirect_pc  input  WIDTH  redirect target.
REQ-008 Port: mem_req  output  1  instruction memory request valid.
REQ-009 Port: mem_addr  output  WIDTH  request address.
REQ-010 Port: mem_ready  input  1  memory accepts request.
REQ-011 Port: mem_rvalid  input  1  read data valid.
REQ-012 Port: mem_rdata  input  WIDTH  read data.
REQ-013 Port: ir_ready  input  1  downstream IR/PC registers may load.
REQ-014 Port: ir_load  output  1  one-cycle load strobe for the IR and PC registers.
REQ-015 Port: ir_data  output  WIDTH  instruction word for the IR.
REQ-016 Port: pc_out  output  WIDTH  address of the instruction in ir_data.
REQ-017 Port: fetch_err  output  1  sticky misaligned-redirect flag.

Function
REQ-018 The FSM SHALL use states IDLE, REQ, WAIT, HOLD and DROP; internal register pc holds the next fetch address.
REQ-019 The block SHALL drive mem_req=1 only in REQ and mem_addr=pc at all times.
REQ-020 IDLE SHALL go to REQ when fetch_en=1 and fetch_err=0; otherwise it SHALL stay in IDLE.
REQ-021 REQ SHALL go to WAIT on a cycle with mem_ready=1; otherwise it SHALL stay in REQ.
REQ-022 WAIT with mem_rvalid=1 and ir_ready=1 SHALL register ir_data<=mem_rdata and pc_out<=pc, SHALL assert ir_load for exactly the next cycle, SHALL set pc<=pc+4 (mod 2^WIDTH), and SHALL go to REQ if fetch_en=1, else to IDLE.
REQ-023 WAIT with mem_rvalid=1 and ir_ready=0 SHALL capture mem_rdata and pc into the hold buffer and SHALL go to HOLD.
REQ-024 HOLD SHALL keep the buffered word until ir_ready=1, then SHALL perform the REQ-022 load and transition using the buffered word.
REQ-025 The block SHALL keep at most one request outstanding; mem_rvalid outside WAIT/DROP SHALL be ignored.
REQ-026 ir_load SHALL never be high on two consecutive cycles; ir_data and pc_out SHALL hold their values while ir_load=0.
REQ-027 A redirect with redirect_pc[1:0]=0 SHALL set pc<=redirect_pc and SHALL take priority over every same-cycle transition.
REQ-028 Redirect targets: IDLE→IDLE (or REQ if fetch_en); REQ with mem_ready=0→REQ at the new pc; REQ with mem_ready=1→DROP; WAIT with mem_rvalid=0→DROP; WAIT with mem_rvalid=1→REQ; HOLD→REQ, discarding the buffer.
REQ-029 No ir_load SHALL occur in the redirect cycle or for any data fetched from a pre-redirect pc.
REQ-030 DROP SHALL discard the next mem_rvalid and then go to REQ (IDLE if fetch_en=0); a further redirect in DROP SHALL only update pc.
REQ-031 A redirect with redirect_pc[1:0]!=0 SHALL set fetch_err=1, leave pc unchanged, and follow REQ-028 but go to IDLE instead of REQ.
REQ-032 fetch_err SHALL clear only on an aligned redirect.
REQ-033 fetch_en=0 SHALL not abort a request in REQ, WAIT or HOLD; it SHALL only block the next request.

Reset
REQ-034 rstn=0 SHALL asynchronously force state=IDLE, pc=RESET_PC, ir_load=0, ir_data=0, pc_out=RESET_PC, fetch_err=0, clear the hold buffer, and hold mem_req=0.
REQ-035 Reset asserted mid-transaction SHALL abandon the outstanding request; the first request after reset release SHALL be to RESET_PC.

Verification
REQ-036 Reset release, fetch_en=1, 1-cycle memory, rdata=0x00000013 -> mem_addr 0,4,8...; ir_load pulses with pc_out=0 and ir_data=0x13 first.
REQ-037 ir_ready=0 for 5 cycles after rvalid=1 with rdata=0xDEADBEEF -> HOLD; no ir_load, mem_req=0; ir_load with 0xDEADBEEF the cycle after ir_ready=1.
REQ-038 Redirect to 0x100 while in WAIT -> the next rvalid is discarded; the next request is addr 0x100; no ir_load for the old address.
REQ-039 Redirect to 0x102 -> fetch_err=1, IDLE, mem_req=0; then redirect to 0x200 -> fetch_err=0, fetch at 0x200.
REQ-040 rstn pulsed low while in WAIT at pc=0x40 -> outputs at reset values immediately; the next request is addr RESET_PC.
REQ-041 pc=0xFFFFFFFC fetched -> the next mem_addr is 0x00000000.
